instr_mem_loader: RTL and testbench

- Write-side counterpart of the fetch stage. It fills instruction memory from an external 8-bit byte stream (UART/JTAG bridge) before the core runs.
- Assembles INSTR_W-bit instructions from bytes, LSB-first, and writes them sequentially through the instruction memory write port, from address 0 up to NUM_INSTRS-1.
- Holds the core (core_hold) for the whole load, so fetch restarts from PC 0 against a complete image.

---
 rtl/instr_mem_loader_pkg.sv | 19 +
 rtl/instr_mem_loader_if.sv | 26 ++
 rtl/instr_mem_loader_byte_assembler.sv | 60 ++++++
 rtl/instr_mem_loader.sv | 126 ++++++++++++
 tb/tb_instr_mem_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared instruction-memory constants and the loader state encoding.
// Widths here are common to the fetch stage and the image loader.
package instr_mem_loader_pkg;

  localparam int INSTR_W         = 19;
  localparam int INSTR_ADDR_W    = 10;
  localparam int NUM_INSTRS      = 512;
  localparam int BYTES_PER_INSTR = (INSTR_W + 7) / 8;
  localparam int ASM_W           = 8 * BYTES_PER_INSTR;
  localparam int BIDX_W          = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte stream in, instruction-memory write port and core hold out.
// Master is the stream source / memory side, slave is the loader.
interface instr_mem_loader_if;

  logic                                    load_start;
  logic [7:0]                              rx_data;
  logic                                    rx_valid;
  logic                                    rx_ready;
  logic                                    mem_we;
  logic [instr_mem_loader_pkg::INSTR_ADDR_W-1:0] mem_waddr;
  logic [instr_mem_loader_pkg::INSTR_W-1:0]      mem_wdata;
  logic                                    core_hold;
  logic                                    load_done;
  logic                                    pad_error;

  modport master (
    output load_start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata, core_hold, load_done, pad_error
  );

  modport slave (
    input  load_start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata, core_hold, load_done, pad_error
  );

endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// Packs stream bytes LSB-first into one instruction word and flags nonzero pad bits.
// word/pad_bad already include the byte presented this cycle, so the caller can latch them on the final accept.
module instr_byte_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         byte_in,
  output logic               last_byte,
  output logic [INSTR_W-1:0] word,
  output logic               pad_bad
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [ASM_W-1:0]  merged;

  assign last_byte = (idx_q == BIDX_W'(BYTES_PER_INSTR - 1));

  always_comb begin
    merged = asm_q;
    for (int k = 0; k < BYTES_PER_INSTR; k++) begin
      if (idx_q == BIDX_W'(k)) begin
        merged[8*k +: 8] = byte_in;
      end
    end

    idx_d = idx_q;
    asm_d = asm_q;
    if (clear) begin
      idx_d = '0;
      asm_d = '0;
    end else if (accept) begin
      // The completed word leaves through 'word'; start the next one empty.
      if (last_byte) begin
        idx_d = '0;
        asm_d = '0;
      end else begin
        idx_d = idx_q + BIDX_W'(1);
        asm_d = merged;
      end
    end
  end

  assign word    = merged[INSTR_W-1:0];
  assign pad_bad = |(merged >> INSTR_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Fills instruction memory from a byte stream while holding the core; one write per assembled word.
// Final byte in cycle N -> mem_we in N+1; rx_ready only in LOAD, so the source holds bytes otherwise.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int NUM_INSTRS = instr_mem_loader_pkg::NUM_INSTRS
) (
  input  logic               clock,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);

  localparam logic [INSTR_ADDR_W-1:0] LAST_ADDR = INSTR_ADDR_W'(NUM_INSTRS - 1);

  loader_state_e           state_q, state_d;
  logic [INSTR_ADDR_W-1:0] addr_q, addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [INSTR_ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [INSTR_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic                    core_hold_q, core_hold_d;
  logic                    load_done_q, load_done_d;
  logic                    pad_error_q, pad_error_d;

  logic               asm_clear;
  logic               asm_accept;
  logic               last_byte;
  logic               pad_bad;
  logic [INSTR_W-1:0] asm_word;

  assign bus.rx_ready = (state_q == ST_LOAD);
  assign asm_accept   = bus.rx_valid && (state_q == ST_LOAD);

  instr_byte_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (asm_clear),
    .accept    (asm_accept),
    .byte_in   (bus.rx_data),
    .last_byte (last_byte),
    .word      (asm_word),
    .pad_bad   (pad_bad)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    core_hold_d = core_hold_q;
    load_done_d = 1'b0;
    pad_error_d = pad_error_q;
    asm_clear   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        core_hold_d = 1'b0;
        if (bus.load_start) begin
          state_d     = ST_LOAD;
          core_hold_d = 1'b1;
          addr_d      = '0;
          pad_error_d = 1'b0;
          asm_clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        // Write strobe and data are registered here so they appear in the WRITE cycle.
        if (asm_accept && last_byte) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_waddr_d = addr_q;
          mem_wdata_d = asm_word;
          if (pad_bad) begin
            pad_error_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d     = ST_DONE;
          load_done_d = 1'b1;
        end else begin
          state_d = ST_LOAD;
          addr_d  = addr_q + INSTR_ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        core_hold_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b0;
      load_done_q <= 1'b0;
      pad_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      core_hold_q <= core_hold_d;
      load_done_q <= load_done_d;
      pad_error_q <= pad_error_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.core_hold = core_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.pad_error = pad_error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader (4-word image) against a byte-level reference model.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int N  = 4;
  localparam int NB = N * BYTES_PER_INSTR;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instr_mem_loader_if io();

  instr_mem_loader #(.NUM_INSTRS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (io)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int                 addr;
    logic [INSTR_W-1:0] data;
    int                 cyc;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   we_cnt      = 0;
  int   done_cnt    = 0;
  int   last_we_cyc = 0;
  logic prev_we     = 1'b0;

  // Reference model: collect bytes, form words with plain arithmetic.
  logic [7:0] model_bytes [BYTES_PER_INSTR];
  int         model_idx  = 0;
  int         model_addr = 0;
  logic       model_pad  = 1'b0;
  logic [7:0] img [NB];

  always @(negedge clock) begin
    if (!reset) begin
      if (io.mem_we) begin
        check_val("we_back_to_back", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          check_val("unexpected_we", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("waddr", 32'(io.mem_waddr), 32'(mon_e.addr));
          check_val("wdata", 32'(io.mem_wdata), 32'(mon_e.data));
          check_val("we_latency", 32'(cyc), 32'(mon_e.cyc));
        end
        we_cnt++;
        last_we_cyc = cyc;
      end
      if (io.load_done) done_cnt++;
    end
    prev_we = io.mem_we;
  end

  task automatic model_word_done();
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < BYTES_PER_INSTR; k++) acc = acc + (32'(model_bytes[k]) << (8 * k));
    exp_q.push_back('{addr: model_addr, data: acc[INSTR_W-1:0], cyc: cyc});
    if ((acc >> INSTR_W) != 0) model_pad = 1'b1;
    model_addr++;
    model_idx = 0;
  endtask

  // Entered and left at posedge+1; the accepting edge is the one after rx_ready is seen at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit start_pulse);
    int n;
    for (int g = 0; g < gap; g++) begin
      io.load_start = start_pulse && (g == 0);
      @(posedge clock); #1;
    end
    io.load_start = 1'b0;
    io.rx_data    = b;
    io.rx_valid   = 1'b1;
    n = 0;
    @(negedge clock);
    while (!io.rx_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("rx_ready_wait", 32'(io.rx_ready), 32'd1);
    check_val("core_hold_load", 32'(io.core_hold), 32'd1);
    @(posedge clock); #1;
    io.rx_valid = 1'b0;
    io.rx_data  = 8'($urandom);
    model_bytes[model_idx] = b;
    model_idx++;
    if (model_idx == BYTES_PER_INSTR) model_word_done();
  endtask

  task automatic start_load();
    @(posedge clock); #1 io.load_start = 1'b1;
    @(posedge clock); #1 io.load_start = 1'b0;
    model_idx  = 0;
    model_addr = 0;
    model_pad  = 1'b0;
    @(negedge clock);
    check_val("start_core_hold", 32'(io.core_hold), 32'd1);
    check_val("start_pad_clear", 32'(io.pad_error), 32'd0);
    check_val("start_rx_ready", 32'(io.rx_ready), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic run_load(input bit gaps, input int pulse_at);
    int n, we0, done0, gap;
    we0   = we_cnt;
    done0 = done_cnt;
    start_load();
    for (int i = 0; i < NB; i++) begin
      gap = gaps ? ((i % 4 == 2) ? 3 : int'($urandom_range(0, 1))) : 0;
      if (i == pulse_at && gap == 0) gap = 1;
      send_byte(img[i], gap, i == pulse_at);
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!io.load_done && n < 30);
    check_val("load_done_seen", 32'(io.load_done), 32'd1);
    check_val("done_after_last_we", 32'(cyc - last_we_cyc), 32'd1);
    check_val("done_core_hold", 32'(io.core_hold), 32'd1);
    check_val("done_pad_error", 32'(io.pad_error), 32'(model_pad));
    @(negedge clock);
    check_val("release_core_hold", 32'(io.core_hold), 32'd0);
    check_val("idle_pad_sticky", 32'(io.pad_error), 32'(model_pad));
    check_val("write_count", 32'(we_cnt - we0), 32'(N));
    check_val("done_count", 32'(done_cnt - done0), 32'd1);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic random_image();
    for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] words [N];
    io.load_start = 1'b0;
    io.rx_valid   = 1'b0;
    io.rx_data    = 8'h00;

    // Reset and quiet idle
    @(negedge clock);
    check_val("reset_ctl", {27'd0, io.rx_ready, io.mem_we, io.core_hold, io.load_done, io.pad_error}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    io.rx_valid = 1'b1;
    io.rx_data  = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_val("idle_ctl", {27'd0, io.rx_ready, io.mem_we, io.core_hold, io.load_done, io.pad_error}, 32'd0);
    end
    check_val("idle_waddr", 32'(io.mem_waddr), 32'd0);
    check_val("idle_wdata", 32'(io.mem_wdata), 32'd0);
    @(posedge clock); #1 io.rx_valid = 1'b0;

    // First word 0x87, no gaps
    random_image();
    img[0] = 8'h87; img[1] = 8'h00; img[2] = 8'h00;
    run_load(1'b0, -1);

    // Fixed image with gaps
    words[0] = 32'h00001; words[1] = 32'h7FFFF; words[2] = 32'h2A2A2; words[3] = 32'h00100;
    for (int i = 0; i < N; i++) begin
      w = words[i];
      for (int k = 0; k < BYTES_PER_INSTR; k++) img[i*BYTES_PER_INSTR + k] = w[8*k +: 8];
    end
    run_load(1'b1, -1);

    // Pad error on word 0, other words clean
    random_image();
    for (int i = 0; i < N; i++) img[i*BYTES_PER_INSTR + 2] = img[i*BYTES_PER_INSTR + 2] & 8'h07;
    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'hFF;
    run_load(1'b1, -1);

    // load_start mid-load is ignored; pad_error cleared by this load's start
    random_image();
    run_load(1'b1, 5);

    // Reset after 4 accepted bytes
    random_image();
    start_load();
    for (int i = 0; i < 4; i++) send_byte(img[i], 0, 1'b0);
    reset = 1'b1;
    #1;
    check_val("rst_core_hold", 32'(io.core_hold), 32'd0);
    check_val("rst_rx_ready", 32'(io.rx_ready), 32'd0);
    check_val("rst_mem_we", 32'(io.mem_we), 32'd0);
    exp_q.delete();
    model_idx = 0;
    @(posedge clock); #1 reset = 1'b0;
    random_image();
    run_load(1'b1, -1);

    // Random images, random ignored start pulses
    for (int r = 0; r < 3; r++) begin
      random_image();
      run_load(1'b1, int'($urandom_range(1, NB - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", vectors, errors);
    $fatal(1);
  end

endmodule
